// File: rtl/io_hub_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : io_hub_pkg
//  Brief    : Shared interrupt FSM encoding and control-register offsets.
//  Revision : 1.0
// ============================================================================
package io_hub_pkg;

    typedef logic [1:0] irq_state_t;

    localparam irq_state_t IRQ_ST_IDLE    = 2'd0;
    localparam irq_state_t IRQ_ST_REQ     = 2'd1;
    localparam irq_state_t IRQ_ST_SERVICE = 2'd2;

    localparam logic [7:0] CTRL_OFS_MASK = 8'd0;
    localparam logic [7:0] CTRL_OFS_PEND = 8'd1;
    localparam int         CTRL_SPAN     = 2;

    // True when the address windows [a_lo, a_lo+a_n) and [b_lo, b_lo+b_n) intersect.
    function automatic bit ranges_overlap(input int a_lo, input int a_n,
                                          input int b_lo, input int b_n);
        return (a_lo < b_lo + b_n) && (b_lo < a_lo + a_n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/io_hub_irq.sv
`default_nettype none
// ============================================================================
//  Module   : io_hub_irq
//  Brief    : IRQ synchronisers, edge detect, mask/pending registers and the
//             IDLE/REQ/SERVICE request-acknowledge state machine.
//  Revision : 1.0
// ============================================================================
module io_hub_irq
    import io_hub_pkg::*;
#(
    parameter int NUM_IRQ = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_IRQ-1:0] i_irq_req,
    input  logic               i_mask_we,
    input  logic               i_pend_we,
    input  logic [NUM_IRQ-1:0] i_wdata,
    input  logic               i_ack,
    output logic [NUM_IRQ-1:0] o_mask,
    output logic [NUM_IRQ-1:0] o_pend,
    output logic               o_interrupt
);

    logic [NUM_IRQ-1:0] r_sync1;
    logic [NUM_IRQ-1:0] r_sync2;
    logic [NUM_IRQ-1:0] r_prev;
    logic [NUM_IRQ-1:0] r_mask;
    logic [NUM_IRQ-1:0] r_pend;
    logic [NUM_IRQ-1:0] w_edge;
    logic [NUM_IRQ-1:0] w_clr;
    irq_state_t         r_state;
    irq_state_t         w_state_nxt;

    // r_prev resets low, so a line already high out of reset registers one edge.
    assign w_edge = r_sync2 & ~r_prev;
    assign w_clr  = i_pend_we ? i_wdata : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_prev  <= '0;
            r_mask  <= '0;
            r_pend  <= '0;
        end else begin
            r_sync1 <= i_irq_req;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
            if (i_mask_we) begin
                r_mask <= i_wdata;
            end
            // OR-ing the edge in last makes a same-cycle set beat the W1C clear.
            r_pend  <= (r_pend & ~w_clr) | w_edge;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IRQ_ST_IDLE: begin
                if ((r_pend & r_mask) != '0) begin
                    w_state_nxt = IRQ_ST_REQ;
                end
            end
            IRQ_ST_REQ: begin
                if (i_ack) begin
                    w_state_nxt = IRQ_ST_SERVICE;
                end
            end
            IRQ_ST_SERVICE: begin
                if (i_pend_we) begin
                    w_state_nxt = IRQ_ST_IDLE;
                end
            end
            default: w_state_nxt = IRQ_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IRQ_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    assign o_mask      = r_mask;
    assign o_pend      = r_pend;
    assign o_interrupt = (r_state == IRQ_ST_REQ);

endmodule
`default_nettype wire

// File: rtl/io_port_hub.sv
`default_nettype none
// ============================================================================
//  Module   : io_port_hub
//  Brief    : Port-mapped I/O hub: output registers, synchronised input
//             channels and an interrupt controller behind an 8-bit port bus.
//  Revision : 1.0
// ============================================================================
module io_port_hub
    import io_hub_pkg::*;
#(
    parameter int         NUM_OUT   = 4,
    parameter int         NUM_IN    = 4,
    parameter int         NUM_IRQ   = 4,
    parameter logic [7:0] OUT_BASE  = 8'h00,
    parameter logic [7:0] IN_BASE   = 8'h20,
    parameter logic [7:0] CTRL_BASE = 8'hF0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [7:0]           port_id,
    input  logic                 write_strobe,
    input  logic                 read_strobe,
    input  logic [7:0]           out_port,
    output logic [7:0]           in_port,
    output logic                 interrupt,
    input  logic                 interrupt_ack,
    output logic [NUM_OUT*8-1:0] pin_out,
    input  logic [NUM_IN*8-1:0]  pin_in,
    input  logic [NUM_IRQ-1:0]   irq_req
);

    localparam bit c_bad_size = (NUM_OUT < 1) || (NUM_OUT > 16) ||
                                (NUM_IN  < 1) || (NUM_IN  > 16) ||
                                (NUM_IRQ < 1) || (NUM_IRQ > 8);
    localparam bit c_bad_span = (int'(OUT_BASE)  + NUM_OUT   > 256) ||
                                (int'(IN_BASE)   + NUM_IN    > 256) ||
                                (int'(CTRL_BASE) + CTRL_SPAN > 256);
    localparam bit c_overlap  =
        ranges_overlap(int'(OUT_BASE), NUM_OUT, int'(IN_BASE),   NUM_IN)    ||
        ranges_overlap(int'(OUT_BASE), NUM_OUT, int'(CTRL_BASE), CTRL_SPAN) ||
        ranges_overlap(int'(IN_BASE),  NUM_IN,  int'(CTRL_BASE), CTRL_SPAN);

    if (c_bad_size || c_bad_span || c_overlap) begin : g_param_check
        $error("io_port_hub: parameter out of range or overlapping address windows");
    end

    logic [NUM_OUT*8-1:0] r_out;
    logic [NUM_IN*8-1:0]  r_in_s1;
    logic [NUM_IN*8-1:0]  r_in_s2;
    logic [7:0]           r_in_port;
    logic [7:0]           w_rdata;
    logic                 w_wr_mask;
    logic                 w_wr_pend;
    logic                 w_rd_mask;
    logic                 w_rd_pend;
    logic [NUM_IRQ-1:0]   w_irq_mask;
    logic [NUM_IRQ-1:0]   w_irq_pend;
    logic [7:0]           w_mask8;
    logic [7:0]           w_pend8;
    logic                 w_unused_rd;

    // Reads are side-effect free and in_port is refreshed every cycle.
    assign w_unused_rd = read_strobe;

    assign w_rd_mask = (port_id == CTRL_BASE + CTRL_OFS_MASK);
    assign w_rd_pend = (port_id == CTRL_BASE + CTRL_OFS_PEND);
    assign w_wr_mask = write_strobe && w_rd_mask;
    assign w_wr_pend = write_strobe && w_rd_pend;

    assign w_mask8 = 8'(w_irq_mask);
    assign w_pend8 = 8'(w_irq_pend);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_out     <= '0;
            r_in_s1   <= '0;
            r_in_s2   <= '0;
            r_in_port <= '0;
        end else begin
            r_in_s1   <= pin_in;
            r_in_s2   <= r_in_s1;
            r_in_port <= w_rdata;
            if (write_strobe) begin
                for (int i = 0; i < NUM_OUT; i++) begin
                    if (port_id == OUT_BASE + 8'(i)) begin
                        r_out[8*i +: 8] <= out_port;
                    end
                end
            end
        end
    end

    // Address windows are disjoint, so at most one branch below can match.
    always_comb begin
        w_rdata = 8'h00;
        for (int i = 0; i < NUM_OUT; i++) begin
            if (port_id == OUT_BASE + 8'(i)) begin
                w_rdata = r_out[8*i +: 8];
            end
        end
        for (int j = 0; j < NUM_IN; j++) begin
            if (port_id == IN_BASE + 8'(j)) begin
                w_rdata = r_in_s2[8*j +: 8];
            end
        end
        if (w_rd_mask) begin
            w_rdata = w_mask8;
        end
        if (w_rd_pend) begin
            w_rdata = w_pend8;
        end
    end

    io_hub_irq #(
        .NUM_IRQ (NUM_IRQ)
    ) u_irq (
        .clk         (clk),
        .rst         (reset),
        .i_irq_req   (irq_req),
        .i_mask_we   (w_wr_mask),
        .i_pend_we   (w_wr_pend),
        .i_wdata     (out_port[NUM_IRQ-1:0]),
        .i_ack       (interrupt_ack),
        .o_mask      (w_irq_mask),
        .o_pend      (w_irq_pend),
        .o_interrupt (interrupt)
    );

    assign pin_out = r_out;
    assign in_port = r_in_port;

endmodule
`default_nettype wire
